// File: rtl/stream_arbiter_if.sv
// Handshake bundle between NREQ requesting streams, the arbiter and the merged downstream port.
// The slave modport is the arbiter's view; the master modport drives the requesters and the sink.
interface stream_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DLEN = 8
) ();
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]      i_valid;
  logic [NREQ-1:0]      o_ready;
  logic [NREQ*DLEN-1:0] i_data;
  logic [NREQ-1:0]      i_last;
  logic                 o_valid;
  logic                 i_ready;
  logic [DLEN-1:0]      o_data;
  logic                 o_last;
  logic [IDW-1:0]       o_id;
  logic                 o_busy;

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_last, o_id, o_busy
  );

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_id, o_busy
  );
endinterface

// File: rtl/stream_arbiter.sv
// Packet-atomic round-robin arbiter: merges NREQ valid/ready streams into one.
// A grant is held from the first beat of a packet until its last beat is accepted.
module stream_arbiter #(
  parameter int NREQ = 4,
  parameter int DLEN = 8
) (
  input  logic               clk,
  input  logic               rstn,
  stream_arbiter_if.slave    bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int PW  = IDW + 1;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t         state_reg;
  logic [IDW-1:0] owner_reg;
  logic [IDW-1:0] rr_ptr_reg;
  logic           busy_reg;

  logic [DLEN-1:0] data_slice [NREQ];
  logic            arb_found;
  logic [IDW-1:0]  arb_idx;
  logic [PW-1:0]   pos_w;
  logic [IDW-1:0]  grant;
  logic            sel_en;
  logic            out_valid;
  logic            out_last;
  logic            hs;
  logic [IDW-1:0]  next_ptr;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign data_slice[gi]  = bus.i_data[gi*DLEN +: DLEN];
      assign bus.o_ready[gi] = (grant == IDW'(gi)) & out_valid & bus.i_ready;
    end
  endgenerate

  // Round-robin scan starting at rr_ptr; the position is wrapped without a modulo operator
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    pos_w     = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos_w = {1'b0, rr_ptr_reg} + PW'(i);
      if (pos_w >= PW'(NREQ)) begin
        pos_w = pos_w - PW'(NREQ);
      end
      if (!arb_found && bus.i_valid[pos_w[IDW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = pos_w[IDW-1:0];
      end
    end
  end

  assign grant     = (state_reg == LOCK) ? owner_reg : arb_idx;
  assign sel_en    = (state_reg == LOCK) | arb_found;
  assign out_valid = sel_en & bus.i_valid[grant];
  assign out_last  = sel_en & bus.i_last[grant];
  assign hs        = out_valid & bus.i_ready;
  assign next_ptr  = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

  assign bus.o_valid = out_valid;
  assign bus.o_last  = out_last;
  assign bus.o_data  = sel_en ? data_slice[grant] : '0;
  assign bus.o_id    = grant;
  assign bus.o_busy  = busy_reg;

  // Any beat that is not a completed last beat pins the grant, so a stalled beat never switches source
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg  <= ARB;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ARB: begin
          if (out_valid) begin
            if (hs && out_last) begin
              rr_ptr_reg <= next_ptr;
            end else begin
              state_reg <= LOCK;
              owner_reg <= grant;
              busy_reg  <= 1'b1;
            end
          end
        end
        LOCK: begin
          if (hs && out_last) begin
            state_reg  <= ARB;
            rr_ptr_reg <= next_ptr;
            busy_reg   <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter (NREQ=4, DLEN=8): each step drives the inputs,
// then compares the combinational outputs against hand-derived values before the next edge.
module tb_stream_arbiter;
  localparam int NREQ = 4;
  localparam int DLEN = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  stream_arbiter_if #(.NREQ(NREQ), .DLEN(DLEN)) sif ();

  stream_arbiter #(.NREQ(NREQ), .DLEN(DLEN)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (sif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sif.o_valid && sif.i_ready)
      $display("xfer t=%0t id=%0d data=%02h last=%0b busy=%0b", $time, sif.o_id, sif.o_data, sif.o_last, sif.o_busy);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
    sif.i_valid = v;
    sif.i_last  = l;
    sif.i_ready = r;
    #1;
  endtask

  function automatic logic [31:0] dat(input int k);
    return 32'hA0 + k;
  endfunction

  initial begin
    sif.i_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    drive(4'b0000, 4'b0000, 1'b0);

    // reset: outputs idle during and after
    rstn = 1'b0;
    tick();
    tick();
    chk("rst_valid", sif.o_valid, 0);
    chk("rst_ready", sif.o_ready, 0);
    chk("rst_busy",  sif.o_busy,  0);
    chk("rst_id",    sif.o_id,    0);
    chk("rst_data",  sif.o_data,  0);
    chk("rst_last",  sif.o_last,  0);
    rstn = 1'b1;
    tick();
    chk("post_rst_valid", sif.o_valid, 0);
    chk("post_rst_ready", sif.o_ready, 0);
    chk("post_rst_busy",  sif.o_busy,  0);

    // all requesters with single-beat packets: rotation 0,1,2,3
    drive(4'b1111, 4'b1111, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("rr_id",    sif.o_id,    k);
      chk("rr_busy",  sif.o_busy,  0);
      chk("rr_ready", sif.o_ready, 32'(1) << k);
      chk("rr_data",  sif.o_data,  dat(k));
      tick();
    end

    // single beat from 1 moves rr_ptr to 2
    drive(4'b0010, 4'b1111, 1'b1);
    chk("pre_id", sif.o_id, 1);
    tick();

    // 3-beat packet from 2 while 0 stays valid
    drive(4'b0101, 4'b1011, 1'b1);
    chk("pkt_b1_id",    sif.o_id,    2);
    chk("pkt_b1_busy",  sif.o_busy,  0);
    chk("pkt_b1_ready", sif.o_ready, 4'b0100);
    chk("pkt_b1_last",  sif.o_last,  0);
    tick();
    chk("pkt_b2_id",    sif.o_id,    2);
    chk("pkt_b2_busy",  sif.o_busy,  1);
    chk("pkt_b2_ready", sif.o_ready, 4'b0100);
    tick();
    drive(4'b0101, 4'b1111, 1'b1);
    chk("pkt_b3_id",   sif.o_id,   2);
    chk("pkt_b3_last", sif.o_last, 1);
    chk("pkt_b3_busy", sif.o_busy, 1);
    tick();
    chk("pkt_after_id",    sif.o_id,    0);
    chk("pkt_after_busy",  sif.o_busy,  0);
    chk("pkt_after_ready", sif.o_ready, 4'b0001);
    tick();

    // rr_ptr wrap: single beat from 2 leaves rr_ptr=3
    drive(4'b0100, 4'b1111, 1'b1);
    chk("wrap_setup_id", sif.o_id, 2);
    tick();
    drive(4'b1001, 4'b1111, 1'b1);
    chk("wrap_id3", sif.o_id, 3);
    tick();
    chk("wrap_id0",   sif.o_id,   0);
    chk("wrap_data0", sif.o_data, dat(0));
    tick();

    // stalled beat from 1 with requester 0 arriving mid-stall
    drive(4'b0010, 4'b0000, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        sif.i_valid = 4'b0011;
        #1;
      end
      chk("stall_id",    sif.o_id,    1);
      chk("stall_data",  sif.o_data,  dat(1));
      chk("stall_ready", sif.o_ready, 0);
      chk("stall_valid", sif.o_valid, 1);
      if (c >= 1) chk("stall_busy", sif.o_busy, 1);
      tick();
    end
    drive(4'b0011, 4'b1111, 1'b1);
    chk("stall_rel_ready", sif.o_ready, 4'b0010);
    tick();

    // bubble: owner 1 drops valid while 3 requests
    drive(4'b0010, 4'b0000, 1'b1);
    chk("bub_first_id", sif.o_id, 1);
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(4'b1000, 4'b0000, 1'b1);
      chk("bub_valid", sif.o_valid, 0);
      chk("bub_ready", sif.o_ready, 0);
      chk("bub_busy",  sif.o_busy,  1);
      chk("bub_id",    sif.o_id,    1);
      tick();
    end
    drive(4'b1010, 4'b1111, 1'b1);
    chk("bub_end_id",    sif.o_id,    1);
    chk("bub_end_valid", sif.o_valid, 1);
    tick();
    chk("bub_next_id",   sif.o_id,   3);
    chk("bub_next_busy", sif.o_busy, 0);
    tick();

    // reset mid-packet with owner 2 and rr_ptr=2
    drive(4'b0010, 4'b1111, 1'b1);
    chk("rmid_pre_id", sif.o_id, 1);
    tick();
    drive(4'b0100, 4'b0000, 1'b1);
    chk("rmid_id", sif.o_id, 2);
    tick();
    chk("rmid_busy", sif.o_busy, 1);
    rstn = 1'b0;
    drive(4'b0110, 4'b0000, 1'b1);
    tick();
    rstn = 1'b1;
    #1;
    chk("rmid_post_busy", sif.o_busy, 0);
    chk("rmid_post_id",   sif.o_id,   1);
    drive(4'b0110, 4'b1111, 1'b1);
    tick();
    chk("rmid_next_id", sif.o_id, 2);

    drive(4'b0000, 4'b0000, 1'b0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
